// File: rtl/wr_logic_param.sv
// Write-domain pointer and flag block for an asynchronous FIFO: binary/Gray write pointers and registered flags.
// Optional macro WR_SYNC_EN adds a 2-flop synchroniser on the incoming Gray read pointer.
module wr_logic_param #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  wr_en,
    input  logic                  clear_ovf,
    input  logic [ADDR_WIDTH:0]   wq2_ptr,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_ack,
    output logic                  overflow
);

    localparam int            PW        = ADDR_WIDTH + 1;
    localparam int            DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down recovers the binary pointer.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q,  wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q,  full_d;
    logic          af_q,    af_d;
    logic          ack_q,   ack_d;
    logic          ovf_q,   ovf_d;
    logic          accept;
    logic [PW-1:0] rq;
    logic [PW-1:0] rbin;

`ifdef WR_SYNC_EN
    logic [PW-1:0] rq_meta_q;
    logic [PW-1:0] rq_sync_q;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            rq_meta_q <= '0;
            rq_sync_q <= '0;
        end else begin
            rq_meta_q <= wq2_ptr;
            rq_sync_q <= rq_meta_q;
        end
    end

    assign rq = rq_sync_q;
`else
    assign rq = wq2_ptr;
`endif

    always_comb begin
        accept  = wr_en & ~full_q;
        wbin_d  = wbin_q + {{(PW-1){1'b0}}, accept};
        wgray_d = bin2gray(wbin_d);
        rbin    = gray2bin(rq);
        level_d = wbin_d - rbin;
        // Full when the next write pointer is exactly one lap ahead of the read pointer.
        full_d  = (wgray_d == {~rq[PW-1:PW-2], rq[PW-3:0]});
        af_d    = (level_d >= AF_THRESH);
        ack_d   = accept;
        // A write attempt while full sets the flag even when a clear arrives on the same edge.
        ovf_d   = (ovf_q & ~clear_ovf) | (wr_en & full_q);
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_ptr      = wbin_q[ADDR_WIDTH-1:0];
    assign wr_ptr_gray = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign wr_ack      = ack_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wr_logic_param.sv
// Scoreboard bench for wr_logic_param: a behavioural occupancy model queues expected outputs per edge.
module tb_wr_logic_param;

    localparam int AW    = 4;
    localparam int AFM   = 2;
    localparam int DEPTH = 1 << AW;
`ifdef WR_SYNC_EN
    localparam int RQ_LAT = 2;
`else
    localparam int RQ_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          clear_ovf;
    logic [AW:0]   wq2_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   wr_ptr_gray;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_level;
    logic          wr_ack;
    logic          overflow;

    wr_logic_param #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
        .wr_clk      (clk),
        .wr_rst_n    (rst_n),
        .wr_en       (wr_en),
        .clear_ovf   (clear_ovf),
        .wq2_ptr     (wq2_ptr),
        .wr_ptr      (wr_ptr),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .wr_ack      (wr_ack),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ack;
        logic          full;
        logic          af;
        logic          ovf;
        logic [AW:0]   lvl;
        logic [AW:0]   gray;
        logic [AW-1:0] ptr;
    } obs_t;

    obs_t exp_q[$];
    obs_t sb_exp;
    obs_t sb_act;
    int   checks   = 0;
    int   failures = 0;
    int   sb_cyc   = 0;

    // Behavioural model: occupancy = writes - reads; full when occupancy reaches DEPTH.
    int m_wbin;
    bit m_full;
    bit m_ovf;
    int rb_d1;
    int rb_d2;

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = AW'(0) + (b & ((1 << (AW + 1)) - 1));
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        m_wbin = 0;
        m_full = 0;
        m_ovf  = 0;
        rb_d1  = 0;
        rb_d2  = 0;
        exp_q.delete();
    endtask

    // Drive one cycle (called at the falling edge), queue the expectation, return at the next falling edge.
    task automatic drive(input logic w, input logic c, input int rb);
        int   eff;
        int   lvl;
        bit   acc;
        bit   novf;
        obs_t e;
        wr_enable_set(w, c, rb);
        eff    = (RQ_LAT == 2) ? rb_d2 : rb;
        rb_d2  = rb_d1;
        rb_d1  = rb;
        acc    = w & ~m_full;
        novf   = (m_ovf & ~c) | (w & m_full);
        m_wbin = (m_wbin + int'(acc)) & 31;
        lvl    = (m_wbin - eff) & 31;
        m_full = (lvl == DEPTH);
        m_ovf  = novf;
        e.ack  = acc;
        e.full = m_full;
        e.af   = (lvl >= DEPTH - AFM);
        e.ovf  = m_ovf;
        e.lvl  = (AW + 1)'(lvl);
        e.gray = to_gray(m_wbin);
        e.ptr  = AW'(m_wbin & (DEPTH - 1));
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_enable_set(input logic w, input logic c, input int rb);
        wr_en     = w;
        clear_ovf = c;
        wq2_ptr   = to_gray(rb);
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            #1;
            if (exp_q.size() > 0) begin
                sb_exp = exp_q.pop_front();
                sb_act = '{ack: wr_ack, full: full, af: almost_full, ovf: overflow,
                           lvl: wr_level, gray: wr_ptr_gray, ptr: wr_ptr};
                sb_cyc++;
                checks++;
                if (sb_act !== sb_exp) begin
                    failures++;
                    $display("FAIL sb_cycle%0d: got ack=%b full=%b af=%b ovf=%b lvl=%0d gray=%b ptr=%0d, want ack=%b full=%b af=%b ovf=%b lvl=%0d gray=%b ptr=%0d",
                             sb_cyc, sb_act.ack, sb_act.full, sb_act.af, sb_act.ovf, sb_act.lvl, sb_act.gray, sb_act.ptr,
                             sb_exp.ack, sb_exp.full, sb_exp.af, sb_exp.ovf, sb_exp.lvl, sb_exp.gray, sb_exp.ptr);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_enable_set(1'b0, 1'b0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({wr_ptr, wr_ptr_gray, wr_level, full, almost_full, wr_ack, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_state: got ptr=%0d gray=%b lvl=%0d full=%b af=%b ack=%b ovf=%b, want all 0",
                     wr_ptr, wr_ptr_gray, wr_level, full, almost_full, wr_ack, overflow);
        end
        repeat (3) drive(1'b1, 1'b0, 0);
        wr_en = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_ptr, wr_ptr_gray, wr_level, full, almost_full, wr_ack, overflow} !== '0) begin
            failures++;
            $display("FAIL async_reset: got ptr=%0d gray=%b lvl=%0d ack=%b, want all 0",
                     wr_ptr, wr_ptr_gray, wr_level, wr_ack);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b0;
        #1;
        checks++;
        if (wr_ptr !== '0 || wr_level !== '0) begin
            failures++;
            $display("FAIL reset_release: got ptr=%0d lvl=%0d, want 0 0", wr_ptr, wr_level);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b0, 0);
            checks++;
            if (wr_level !== (AW + 1)'(i) || almost_full !== (i >= DEPTH - AFM) || full !== (i == DEPTH)) begin
                failures++;
                $display("FAIL fill_%0d: got lvl=%0d af=%b full=%b, want lvl=%0d af=%b full=%b",
                         i, wr_level, almost_full, full, i, (i >= DEPTH - AFM), (i == DEPTH));
            end
        end
        checks++;
        if (wr_ptr_gray !== 5'b11000) begin
            failures++;
            $display("FAIL fill_gray: got %b, want 11000", wr_ptr_gray);
        end
    endtask

    task automatic test_overflow();
        repeat (3) drive(1'b1, 1'b0, 0);
        checks++;
        if (wr_ptr !== '0 || wr_ack !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got ptr=%0d ack=%b ovf=%b, want 0 0 1", wr_ptr, wr_ack, overflow);
        end
        drive(1'b1, 1'b1, 0);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins: got %b, want 1", overflow);
        end
        drive(1'b0, 1'b1, 0);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b, want 0", overflow);
        end
    endtask

    task automatic test_drain();
        repeat (RQ_LAT + 1) drive(1'b0, 1'b0, 1);
        checks++;
        if (full !== 1'b0 || wr_level !== 5'd15) begin
            failures++;
            $display("FAIL drain_release: got full=%b lvl=%0d, want 0 15", full, wr_level);
        end
        drive(1'b1, 1'b0, 1);
        checks++;
        if (full !== 1'b1 || wr_ack !== 1'b1 || wr_level !== 5'd16) begin
            failures++;
            $display("FAIL drain_refill: got full=%b ack=%b lvl=%0d, want 1 1 16", full, wr_ack, wr_level);
        end
    endtask

    task automatic test_wrap();
        logic [AW:0] prev_gray;
        do_reset();
        repeat (3) drive(1'b1, 1'b0, 0);
        for (int k = 0; k < 40; k++) begin
            prev_gray = wr_ptr_gray;
            drive(1'b1, 1'b0, k + 1);
            checks++;
            if ($countones(prev_gray ^ wr_ptr_gray) != 1) begin
                failures++;
                $display("FAIL wrap_gray_step%0d: got %b -> %b, want one-bit change", k, prev_gray, wr_ptr_gray);
            end
            if (k >= 2) begin
                checks++;
                if (wr_level !== (AW + 1)'(3 + RQ_LAT)) begin
                    failures++;
                    $display("FAIL wrap_level%0d: got %0d, want %0d", k, wr_level, 3 + RQ_LAT);
                end
            end
        end
        checks++;
        if (wr_ptr !== 4'd11) begin
            failures++;
            $display("FAIL wrap_ptr: got %0d, want 11", wr_ptr);
        end
    endtask

    task automatic test_sync_latency();
        int n;
        do_reset();
        repeat (DEPTH) drive(1'b1, 1'b0, 0);
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL lat_prefull: got %b, want 1", full);
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1);
            n++;
            if (full === 1'b0) break;
        end
        checks++;
        if (full !== 1'b0 || n != RQ_LAT + 1) begin
            failures++;
            $display("FAIL lat_edges: got %0d edges (full=%b), want %0d", n, full, RQ_LAT + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_enable_set(1'b0, 1'b0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_sync_latency();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
